// File: rtl/commit_trace_ctrl_if.sv
// rtl/commit_trace_ctrl_if.sv - commit and trace-sink handshake bundle
//
// Purpose: groups the core commit channel (cm_*) and the trace/difftest sink
// channel (dt_*) used by commit_trace_ctrl.
//   master : core/sink side  - drives cm_* requests and dt_ready
//   slave  : controller side - drives cm_ready and the dt_* record
interface commit_trace_ctrl_if #(
  parameter int XLEN = 64
);
  logic            cm_valid;
  logic            cm_ready;
  logic [XLEN-1:0] cm_pc;
  logic [XLEN-1:0] cm_dnpc;
  logic [31:0]     cm_inst;
  logic            cm_is_break;
  logic [XLEN-1:0] cm_a0;

  logic            dt_valid;
  logic            dt_ready;
  logic [XLEN-1:0] dt_pc;
  logic [XLEN-1:0] dt_dnpc;
  logic [31:0]     dt_inst;

  modport master (
    output cm_valid, cm_pc, cm_dnpc, cm_inst, cm_is_break, cm_a0, dt_ready,
    input  cm_ready, dt_valid, dt_pc, dt_dnpc, dt_inst
  );

  modport slave (
    input  cm_valid, cm_pc, cm_dnpc, cm_inst, cm_is_break, cm_a0, dt_ready,
    output cm_ready, dt_valid, dt_pc, dt_dnpc, dt_inst
  );
endinterface

// File: rtl/commit_trace_ctrl.sv
// rtl/commit_trace_ctrl.sv - commit record FIFO and ebreak halt sequencer
//
// Purpose: buffers retired-instruction records (pc, dnpc, inst) and hands
// them to the trace/difftest sink one per cycle. An accepted ebreak stops
// intake, drains the FIFO, then raises a sticky halt with the captured a0.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - commit_trace_ctrl_if.slave (cm_* in, dt_* out)
//   halt        - sticky, ebreak retired and all records drained
//   halt_code   - a0 captured with the ebreak
//   commit_cnt  - records delivered to the sink
// Build option: define COMMIT_CNT_EN to implement commit_cnt; otherwise it
// is tied to zero and no counter flops exist.
module commit_trace_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                clk,
  input  logic                rst,
  commit_trace_ctrl_if.slave  bus,
  output logic                halt,
  output logic [XLEN-1:0]     halt_code,
  output logic [63:0]         commit_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] dnpc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            enq, deq;

  // Ready depends only on registered state: no accept into a full FIFO even
  // when a dequeue happens in the same cycle.
  assign bus.cm_ready = (state == ST_RUN) && (count != FULL);
  assign bus.dt_valid = (count != '0);
  assign bus.dt_pc    = pc_mem[rd_ptr];
  assign bus.dt_dnpc  = dnpc_mem[rd_ptr];
  assign bus.dt_inst  = inst_mem[rd_ptr];
  assign enq          = bus.cm_valid && bus.cm_ready;
  assign deq          = bus.dt_valid && bus.dt_ready;
  assign halt         = (state == ST_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (enq && bus.cm_is_break) state_nxt = ST_DRAIN;
      // No enqueue in DRAIN, so the last dequeue empties the FIFO and halt
      // shows up in the following cycle.
      ST_DRAIN: if (deq && (count == ONE)) state_nxt = ST_HALT;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      halt_code <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (enq && bus.cm_is_break) halt_code <= bus.cm_a0;
    end
  end

  // Record storage carries no reset; contents are only read while valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= bus.cm_pc;
      dnpc_mem[wr_ptr] <= bus.cm_dnpc;
      inst_mem[wr_ptr] <= bus.cm_inst;
    end
  end

`ifdef COMMIT_CNT_EN
  logic [63:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (deq) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign commit_cnt = cnt_q;
`else
  assign commit_cnt = '0;
`endif
endmodule

// File: tb/tb_commit_trace_ctrl.sv
// tb/tb_commit_trace_ctrl.sv - randomized bench for commit_trace_ctrl against a queue model
module tb_commit_trace_ctrl;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] dnpc;
    logic [31:0] inst;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt;
  logic [63:0] halt_code;
  logic [63:0] commit_cnt;

  commit_trace_ctrl_if #(.XLEN(XLEN)) bus ();

  commit_trace_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .halt       (halt),
    .halt_code  (halt_code),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: ordered queue of outstanding records plus run/drain/halt mode.
  rec_t        q[$];
  int          m_mode;      // 0 run, 1 draining after ebreak, 2 halted
  logic [63:0] m_code;
  logic [63:0] m_cnt;
  bit          acc;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (m_mode == 0) && (q.size() < DEPTH);
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef COMMIT_CNT_EN
    return m_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic check_all();
    check("cm_ready", {63'd0, bus.cm_ready}, {63'd0, m_ready()});
    check("dt_valid", {63'd0, bus.dt_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("dt_pc",   bus.dt_pc,   q[0].pc);
      check("dt_dnpc", bus.dt_dnpc, q[0].dnpc);
      check("dt_inst", {32'd0, bus.dt_inst}, {32'd0, q[0].inst});
    end
    check("halt",       {63'd0, halt}, {63'd0, m_mode == 2});
    check("halt_code",  halt_code,  m_code);
    check("commit_cnt", commit_cnt, exp_cnt());
  endtask

  // Called with inputs set during clock-low; applies the edge to the model
  // and the DUT, then checks everything on the next falling edge.
  task automatic cycle();
    rec_t r;
    rec_t dummy;
    bit   dv;
    acc = m_ready() && bus.cm_valid;
    dv  = (q.size() != 0);
    if (dv && bus.dt_ready) begin
      dummy = q.pop_front();
      m_cnt = m_cnt + 64'd1;
    end
    if (acc) begin
      r.pc = bus.cm_pc; r.dnpc = bus.cm_dnpc; r.inst = bus.cm_inst;
      q.push_back(r);
      if (bus.cm_is_break) begin
        m_code = bus.cm_a0;
        m_mode = 1;
      end
    end
    if (m_mode == 1 && q.size() == 0) m_mode = 2;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic new_rec();
    bus.cm_pc   = {$urandom, $urandom};
    bus.cm_dnpc = {$urandom, $urandom};
    bus.cm_inst = $urandom;
    bus.cm_a0   = {$urandom, $urandom};
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_dt_valid",   {63'd0, bus.dt_valid}, 64'd0);
    check("rst_halt",       {63'd0, halt}, 64'd0);
    check("rst_halt_code",  halt_code, 64'd0);
    check("rst_commit_cnt", commit_cnt, 64'd0);
    check("rst_cm_ready",   {63'd0, bus.cm_ready}, 64'd1);
    q.delete();
    m_mode = 0; m_code = '0; m_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] obs[$];
    int n;
    int guard;
    int deqs;
    bus.cm_valid = 0; bus.cm_is_break = 0; bus.dt_ready = 0;
    bus.cm_pc = 0; bus.cm_dnpc = 0; bus.cm_inst = 0; bus.cm_a0 = 0;
    m_mode = 0; m_code = '0; m_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Single commit with the sink ready: visible next cycle, gone the cycle after.
    bus.cm_valid = 1; bus.cm_pc = 64'h8000_0000; bus.cm_dnpc = 64'h8000_0004;
    bus.cm_inst = 32'h0000_0413; bus.dt_ready = 1;
    cycle();
    check("t1_dt_valid", {63'd0, bus.dt_valid}, 64'd1);
    check("t1_dt_pc", bus.dt_pc, 64'h8000_0000);
    bus.cm_valid = 0;
    cycle();
    check("t1_dt_valid_after", {63'd0, bus.dt_valid}, 64'd0);

    // Fill with the sink stalled; the fifth commit is held until space frees.
    bus.dt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.cm_valid = 1; bus.cm_pc = 64'h8000_0000 + 64'(4 * i);
      bus.cm_dnpc = bus.cm_pc + 4; bus.cm_inst = $urandom;
      cycle();
    end
    check("t2_full_cm_ready", {63'd0, bus.cm_ready}, 64'd0);
    bus.cm_pc = 64'h8000_0010; bus.cm_dnpc = 64'h8000_0014;
    cycle();
    cycle();
    bus.dt_ready = 1;
    guard = 0;
    while ((bus.cm_valid || q.size() != 0) && guard < 20) begin
      if (bus.dt_valid) obs.push_back(bus.dt_pc);
      cycle();
      if (acc) bus.cm_valid = 0;
      guard++;
    end
    check("t2_drain_count", 64'(obs.size()), 64'd5);
    for (int i = 0; i < obs.size() && i < 5; i++)
      check("t2_order", obs[i], 64'h8000_0000 + 64'(4 * i));

    // Streaming: one record per cycle with pointer wrap.
    bus.cm_valid = 1; bus.dt_ready = 1;
    for (int i = 0; i < 20; i++) begin
      new_rec();
      cycle();
    end
    bus.cm_valid = 0;
    cycle();

    // Random traffic without ebreak.
    for (int i = 0; i < 300; i++) begin
      bus.cm_valid = ($urandom % 4) != 0;
      bus.dt_ready = ($urandom % 3) != 0;
      cycle();
      if (acc) new_rec();
    end

    // Ebreak behind 3 records, a0=0; core keeps pushing afterwards.
    do_reset();
    bus.dt_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.cm_valid = 1; new_rec();
      cycle();
    end
    bus.cm_is_break = 1; bus.cm_a0 = 64'd0; new_rec(); bus.cm_a0 = 64'd0;
    cycle();
    check("t4_cm_ready_drain", {63'd0, bus.cm_ready}, 64'd0);
    bus.cm_is_break = 0; new_rec(); bus.dt_ready = 1;
    deqs = 0; guard = 0;
    while (!halt && guard < 20) begin
      if (bus.dt_valid) deqs++;
      cycle();
      guard++;
    end
    check("t4_halt", {63'd0, halt}, 64'd1);
    check("t4_deqs", 64'(deqs), 64'd4);
    check("t4_halt_code", halt_code, 64'd0);
    cycle();
    check("t4_halt_sticky", {63'd0, halt}, 64'd1);
    bus.cm_valid = 0;

    // Ebreak a0=1 with a stalled sink mid-drain.
    do_reset();
    bus.dt_ready = 0; bus.cm_valid = 1; new_rec();
    cycle();
    bus.cm_is_break = 1; new_rec(); bus.cm_a0 = 64'd1;
    cycle();
    bus.cm_is_break = 0; bus.cm_valid = 0;
    bus.dt_ready = 1;
    cycle();
    bus.dt_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_halt_stalled", {63'd0, halt}, 64'd0);
    end
    bus.dt_ready = 1;
    guard = 0;
    while (!halt && guard < 10) begin
      cycle();
      guard++;
    end
    check("t5_halt", {63'd0, halt}, 64'd1);
    check("t5_halt_code", halt_code, 64'd1);

    // Deliver 7 records, then reset during a drain with 2 queued.
    do_reset();
    bus.cm_valid = 1; bus.dt_ready = 1;
    for (int i = 0; i < 7; i++) begin
      new_rec();
      cycle();
    end
    bus.cm_valid = 0;
    cycle();
`ifdef COMMIT_CNT_EN
    check("t6_cnt7", commit_cnt, 64'd7);
`else
    check("t6_cnt7", commit_cnt, 64'd0);
`endif
    bus.dt_ready = 0; bus.cm_valid = 1; new_rec();
    cycle();
    bus.cm_is_break = 1; new_rec();
    cycle();
    bus.cm_is_break = 0; bus.cm_valid = 0;
    check("t6_queued", 64'(q.size()), 64'd2);
    do_reset();
    check_all();
    cycle();

    // Random episodes that may hit ebreak.
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 150 && m_mode != 2; i++) begin
        bus.cm_valid    = ($urandom % 4) != 0;
        bus.dt_ready    = ($urandom % 3) != 0;
        bus.cm_is_break = ($urandom % 25) == 0;
        cycle();
        if (acc) new_rec();
      end
      bus.cm_is_break = 0;
      cycle();
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_trace_ctrl.md
Name: commit_trace_ctrl

Overview:
- Sequences core commit events toward the DPI difftest/trace sink.
- Buffers retired-instruction records (pc, dnpc, inst) in a small FIFO and presents them to the sink one per cycle under valid/ready.
- Runs the ebreak halt sequence: stops intake, drains outstanding records, then raises a sticky halt carrying the exit code (a0).
- Sits between the writeback stage and the simulation-only trace/difftest model.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- XLEN, 64, pc/dnpc/a0 width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- cm_valid  in  1  core presents a committed instruction.
- cm_ready  out  1  controller accepts the commit this cycle.
- cm_pc  in  XLEN  pc of committed instruction.
- cm_dnpc  in  XLEN  next pc after commit.
- cm_inst  in  32  instruction word.
- cm_is_break  in  1  committed instruction is ebreak.
- cm_a0  in  XLEN  value of x10 at commit; sampled only on ebreak.
- dt_valid  out  1  record available to sink.
- dt_ready  in  1  sink consumes record.
- dt_pc  out  XLEN  head record pc.
- dt_dnpc  out  XLEN  head record dnpc.
- dt_inst  out  32  head record inst.
- halt  out  1  sticky: ebreak retired and all records drained.
- halt_code  out  XLEN  captured a0.
- commit_cnt  out  64  records delivered to sink (see optional feature).

Behaviour:
- Reset (async, any time, including mid-drain):
  - State is RUN; FIFO pointers and count are 0.
  - dt_valid=0, halt=0, halt_code=0, commit_cnt=0, cm_ready=1 once released.
  - Buffer contents are don't-care.
- Handshakes:
  - Enqueue when cm_valid & cm_ready.
  - Dequeue when dt_valid & dt_ready.
- cm_ready = (state==RUN) & (count<DEPTH). This is combinational from registered state only. No accept-when-full-with-simultaneous-dequeue.
- dt_valid = (count!=0). dt_* are driven from the head entry.
- Latency: a record enqueued in cycle N is visible on dt_* in cycle N+1 (no fall-through). Throughput is 1 record per cycle.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Record order is strictly FIFO; no record is dropped or duplicated.
- FSM:
  - RUN: an accepted commit with cm_is_break=1 is enqueued like any other record. In the same edge, halt_code <= cm_a0 and the FSM goes to DRAIN.
  - DRAIN: cm_ready=0. When count reaches 0 (after the ebreak record is dequeued), go to HALT.
  - HALT: halt=1 and cm_ready=0. dt_valid stays 0. Exit only via rst.
- halt rises in the cycle after the final dequeue edge.
- cm_is_break is ignored when there is no handshake.
- cm_valid asserted in DRAIN or HALT is never accepted; the core must hold it.
- dt_ready while dt_valid=0 has no effect.

Optional Feature:
- COMMIT_CNT_EN defined:
  - commit_cnt increments by 1 on every dequeue handshake.
  - It is a 64-bit counter that wraps to 0 after all-ones.
  - It holds its value in HALT and clears on rst.
- COMMIT_CNT_EN undefined: commit_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then commit pc=0x80000000/inst=0x00000413 with dt_ready=1 -> dt_valid=1 next cycle with dt_pc=0x80000000; dt_valid=0 the following cycle; halt=0.
- dt_ready=0, 5 back-to-back commits with DEPTH=4 -> cm_ready drops after the 4th accept and the 5th is held. Then dt_ready=1 -> records pc 0x80000000,04,08,0C emerge in order, then the 5th.
- Continuous cm_valid and dt_ready for 20 cycles -> one record per cycle, pointers wrap, no gaps after the first, order preserved.
- With 3 queued records, commit ebreak with cm_a0=0x0, then assert cm_valid again -> cm_ready=0 from the next cycle. Exactly 4 records drain, halt=1 one cycle after the last dequeue, halt_code=0.
- Ebreak with cm_a0=0x1, sink stalled for 3 cycles mid-drain -> halt stays 0 until drained, then halt=1 and halt_code=0x1.
- Assert rst during DRAIN with 2 records queued -> immediately dt_valid=0, halt=0, commit_cnt=0, state RUN. With COMMIT_CNT_EN, 7 delivered records before reset -> commit_cnt=7 beforehand.
